// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcodes, nop word and fetch-stage types
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_NOP    = 7'b0000000;

  // Empty decode slots carry this word; the control decoder treats it as a nop.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_DROP
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small instruction buffer holding {pc, instr} pairs
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         head_valid,
  output fetch_entry_t                 head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign head_valid = (count != '0);
  assign do_pop     = pop && head_valid;
  // Head is read straight from the storage registers, never from the push path.
  assign head_data  = mem[rd_ptr];

  // Pointer and occupancy update; flush empties the buffer and wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are only observable once counted as valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, request issue, response drop and decode hand-off
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   pc;
  logic [CW-1:0] outst;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [31:0]   pq_mem [DEPTH];
  logic [AW-1:0] pq_wr;
  logic [AW-1:0] pq_rd;
  logic          head_valid;
  fetch_entry_t  head_data;
  fetch_entry_t  push_data;
  logic [CW:0]   used;
  logic          credit;
  logic          pop;
  logic          push;
  logic          accept;

  // Outstanding requests plus buffered words must stay below DEPTH after this cycle's pop.
  assign pop    = head_valid && !stall;
  assign used   = {1'b0, outst} + {1'b0, fifo_count} - (CW+1)'(pop);
  assign credit = used < (CW+1)'(DEPTH);
  assign accept = imem_req && imem_ready;
  // A response landing in a redirect cycle belongs to the old path and is dropped.
  assign push   = imem_rvalid && (drop_cnt == '0) && !redirect;

  assign push_data.pc    = pq_mem[pq_rd];
  assign push_data.instr = imem_rdata;
  assign imem_addr       = pc;

  assign id_valid = head_valid;
  assign id_instr = head_valid ? head_data.instr : NOP_INSTR;
  assign id_pc    = head_valid ? head_data.pc : 32'h0;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .flush      (redirect),
    .count      (fifo_count),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_BOOT;
    else        state <= state_nxt;
  end

  // Next state: boot lasts one cycle; a redirect with requests in flight enters the drop phase.
  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:  state_nxt = S_FETCH;
      S_FETCH: if (redirect && (outst != '0)) state_nxt = S_DROP;
      S_DROP: begin
        if (redirect && (outst != '0)) state_nxt = S_DROP;
        else if (drop_cnt == '0)       state_nxt = S_FETCH;
      end
      default: state_nxt = S_BOOT;
    endcase
  end

  // Request issue; the redirect gate keeps the stale PC from ever going out.
  always_comb begin
    imem_req = 1'b0;
    if (state != S_BOOT) imem_req = credit && !redirect;
  end

  // PC, in-flight count and drop count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      outst    <= '0;
      drop_cnt <= '0;
    end else begin
      outst <= outst + CW'(accept) - CW'(imem_rvalid);
      if (redirect) begin
        pc       <= redirect_pc & 32'hFFFF_FFFC;
        drop_cnt <= outst - CW'(imem_rvalid);
      end else begin
        if (accept) pc <= pc + 32'd4;
        if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // Request-PC queue pointers; responses come back in order so a ring suffices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pq_wr <= '0;
      pq_rd <= '0;
    end else begin
      if (accept)      pq_wr <= pq_wr + 1'b1;
      if (imem_rvalid) pq_rd <= pq_rd + 1'b1;
    end
  end

  // Request-PC queue storage.
  always_ff @(posedge clk) begin
    if (accept) pq_mem[pq_wr] <= pc;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  int          errors = 0;
  int          checks = 0;
  int          lat = 1;
  logic        pv [4];
  logic [31:0] pa [4];
  logic [31:0] exp_pop;
  logic [31:0] exp_req;
  int          pops;

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a + 32'h1000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0;
      pa[i] = 32'h0;
    end
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
  endtask

  // Advance one cycle: memory model shifts, then next-cycle inputs are applied.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
    logic        acc;
    logic [31:0] aa;
    acc = rst_n && imem_req && imem_ready;
    aa  = imem_addr;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      clear_mem();
    end else begin
      for (int i = 3; i > 0; i--) begin
        pv[i] = pv[i-1];
        pa[i] = pa[i-1];
      end
      pv[0] = acc;
      pa[0] = aa;
      imem_rvalid = pv[lat-1];
      imem_rdata  = pv[lat-1] ? word_of(pa[lat-1]) : 32'hDEAD_BEEF;
    end
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ready  = rdy;
    #2;
  endtask

  task automatic cyc();
    step(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic do_release();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_mem();
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    imem_ready = 1'b1;
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    imem_ready = 1'b1;
    clear_mem();
    cyc();
    cyc();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);

    // Section A: 1-cycle memory, startup, stall, redirect coinciding with rvalid and stall
    lat = 1;
    do_release();
    chk("boot_req", imem_req, 0);
    cyc();
    chk("c2_req", imem_req, 1);
    chk("c2_addr", imem_addr, 32'h0);
    cyc();
    chk("c3_addr", imem_addr, 32'h4);
    chk("c3_id_valid", id_valid, 0);
    cyc();
    chk("c4_id_valid", id_valid, 1);
    chk("c4_id_pc", id_pc, 32'h0);
    chk("c4_id_instr", id_instr, word_of(32'h0));
    cyc();
    chk("c5_id_pc", id_pc, 32'h4);
    cyc();
    chk("c6_id_pc", id_pc, 32'h8);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall1_id_pc", id_pc, 32'hC);
    chk("stall1_req", imem_req, 0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall2_id_pc", id_pc, 32'hC);
    chk("stall2_req", imem_req, 0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall3_id_instr", id_instr, word_of(32'hC));
    chk("stall3_req", imem_req, 0);
    cyc();
    chk("rel_id_pc", id_pc, 32'hC);
    chk("rel_req", imem_req, 1);
    chk("rel_addr", imem_addr, 32'h14);
    cyc();
    chk("rel1_id_pc", id_pc, 32'h10);
    step(1'b1, 1'b1, 32'h0000_0103, 1'b1);
    chk("rdr_req_gated", imem_req, 0);
    cyc();
    chk("rdr_id_valid", id_valid, 0);
    chk("rdr_id_instr", id_instr, 32'h0);
    chk("rdr_id_pc", id_pc, 32'h0);
    chk("rdr_req", imem_req, 1);
    chk("rdr_addr", imem_addr, 32'h100);
    cyc();
    chk("rdr_gap_valid", id_valid, 0);
    cyc();
    chk("rdr_first_valid", id_valid, 1);
    chk("rdr_first_pc", id_pc, 32'h100);
    chk("rdr_first_instr", id_instr, word_of(32'h100));
    cyc();
    chk("rdr_next_pc", id_pc, 32'h104);

    // Section B: 2-cycle memory, redirect with one request in flight
    rst_n = 1'b0;
    lat = 2;
    cyc();
    cyc();
    do_release();
    cyc();
    chk("b_c2_addr", imem_addr, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    chk("b_rdr_req", imem_req, 0);
    cyc();
    chk("b_c4_addr", imem_addr, 32'h100);
    chk("b_c4_valid", id_valid, 0);
    cyc();
    chk("b_stale_valid", id_valid, 0);
    chk("b_stale_instr", id_instr, 32'h0);
    cyc();
    chk("b_c6_valid", id_valid, 0);
    cyc();
    chk("b_first_pc", id_pc, 32'h100);
    chk("b_first_instr", id_instr, word_of(32'h100));

    // Section C: 3-cycle memory, random ready/stall, periodic redirects, PC wrap
    rst_n = 1'b0;
    lat = 3;
    cyc();
    cyc();
    do_release();
    chk("c_boot_req", imem_req, 0);
    exp_pop = 32'h0;
    exp_req = 32'h0;
    pops = 0;
    for (int n = 0; n < 400; n++) begin
      logic        rd;
      logic        st;
      logic [31:0] rpc;
      rd  = (n % 37 == 20) || (n == 200);
      rpc = (n == 200) ? 32'hFFFF_FFF9 : ($urandom & 32'h0000_FFFF);
      st  = ($urandom_range(0, 3) == 0);
      step(st, rd, rpc, 1'($urandom_range(0, 1)));
      if (rd) chk("c_req_in_redirect", imem_req, 0);
      if (imem_req && imem_ready) begin
        chk("c_req_addr", imem_addr, exp_req);
        exp_req = exp_req + 32'd4;
      end
      if (!id_valid) chk("c_empty_instr", id_instr, 32'h0);
      if (!rd && id_valid && !st) begin
        chk("c_pop_pc", id_pc, exp_pop);
        chk("c_pop_instr", id_instr, word_of(exp_pop));
        exp_pop = exp_pop + 32'd4;
        pops++;
      end
      if (rd) begin
        exp_req = rpc & 32'hFFFF_FFFC;
        exp_pop = rpc & 32'hFFFF_FFFC;
      end
      chk("c_no_overflow", 32'(32'(dut.outst) + 32'(dut.fifo_count) <= 2), 1);
    end
    chk("c_progress", 32'(pops > 20), 1);

    // Section D: asynchronous reset mid-stream, then restart at RESET_PC
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req", imem_req, 0);
    chk("async_addr", imem_addr, 32'h0);
    chk("async_id_valid", id_valid, 0);
    chk("async_id_instr", id_instr, 32'h0);
    chk("async_id_pc", id_pc, 32'h0);
    lat = 1;
    cyc();
    cyc();
    do_release();
    chk("d_boot_req", imem_req, 0);
    cyc();
    chk("d_c2_req", imem_req, 1);
    chk("d_c2_addr", imem_addr, 32'h0);
    cyc();
    cyc();
    chk("d_c4_pc", id_pc, 32'h0);
    chk("d_c4_valid", id_valid, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage: owns the PC, issues in-order requests to instruction memory, buffers returned words in a small FIFO, and presents one instruction per cycle to decode, where the opcode field drives the main control decoder. It handles redirects from branch/jump resolution and stalls from hazard logic. Invalid slots are presented as the all-zero word, which the control decoder treats as a nop.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 2: FIFO entries; also the cap on outstanding requests plus buffered entries. Power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address, word-aligned.
- `imem_ready`  in  1  memory accepts the request this cycle; transfer occurs when `imem_req && imem_ready`.
- `imem_rvalid`  in  1  response word valid. Responses are strictly in request order, at least 1 cycle after acceptance.
- `imem_rdata`  in  32  response instruction.
- `redirect`  in  1  branch/jump taken; restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new PC; bits [1:0] ignored (forced 0).
- `stall`  in  1  decode cannot accept; hold the head entry.
- `id_valid`  out  1  head entry valid.
- `id_instr`  out  32  head instruction; 32'h0 when `!id_valid`.
- `id_pc`  out  32  PC of the head instruction; 0 when `!id_valid`.

## Operation
- FSM `S_BOOT` → `S_FETCH` ↔ `S_DROP`.
  - `S_BOOT`: the only state entered on reset; lasts exactly one cycle with `imem_req`=0, then `S_FETCH`.
  - `S_FETCH`: normal fetching.
  - `S_DROP`: entered on `redirect` when outstanding > 0. Returns to `S_FETCH` when `drop_cnt` reaches 0. Requests may still issue in this state.
- Counters: `outst` (0..DEPTH) and `drop_cnt` (0..DEPTH).
- `pop = id_valid && !stall`.
- Credit: `outst + count - pop < DEPTH`.
- `imem_req = (state != S_BOOT) && credit && !redirect`. The combinational gate on `redirect` guarantees that no stale-PC request issues.
- On accept, `pc += 4` (wraps modulo 2^32), `outst += 1`.
- On `imem_rvalid`, `outst -= 1`:
  - If `drop_cnt > 0`: discard the word and decrement `drop_cnt`.
  - Otherwise: push `{pc_of_req, rdata}`. Track request PCs in a parallel DEPTH-entry PC queue.
- On `redirect`:
  - Flush the FIFO (count=0).
  - `pc <= {redirect_pc[31:2],2'b00}`.
  - `drop_cnt <= outst - (imem_rvalid ? 1 : 0)`. A response arriving in the redirect cycle is itself discarded.
- Priority: `redirect` > `stall`. Push and pop in the same cycle are legal; with count=DEPTH, push occurs only alongside a pop, which credit guarantees.
- FIFO overflow is unreachable by credit. The bench asserts it never occurs.
- Reset mid-operation: all state clears immediately. Responses to pre-reset requests are the memory's responsibility (memory resets on the same `rst_n`).

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `id_valid`=0, `id_instr`=0, `id_pc`=0.
  - `outst`=`drop_cnt`=count=0, state=`S_BOOT`.
- First `imem_req` is in the 2nd cycle after `rst_n` deasserts.
- Latency: request accepted cycle N, `imem_rvalid` cycle N+k, `id_valid` cycle N+k+1. The outputs come from registered FIFO head; there is no comb bypass from `imem_rdata`.
- Throughput: 1 instr/cycle sustained with k=1, DEPTH=2, no stall.
- After `redirect` at cycle R:
  - `id_valid`=0 at R+1.
  - First request to `redirect_pc` at R+1 if credit allows.
- `stall` holds `id_instr`/`id_pc` stable and blocks pop. Fetch continues until credit is exhausted.

## Structure
- Shared package `riscv_pkg`:
  - Opcode constants (R-type, I-type, branch, load, store, LUI, AUIPC, JAL, JALR, nop=7'b0).
  - `NOP_INSTR` = 32'h0.
  - `fetch_state_t` enum.
- Sub-module `fetch_fifo`: parameterised DEPTH×64 FIFO with `push`/`pop`/`flush`/`count` and registered head outputs. `fetch_unit` holds the PC, FSM, counters and credit logic.

## Test plan
- Reset release, `imem_ready`=1, 1-cycle memory returning addr-derived words:
  - Requests go to 0x0, 0x4, 0x8… from cycle 2.
  - `id_valid` first at cycle 4 with `id_pc`=0.
  - Then 1 instr/cycle.
- Stall 3 cycles with FIFO filling:
  - `id_instr` is held.
  - `imem_req` drops once `outst+count`=2.
  - No instruction is lost or duplicated on release.
- Redirect to 0x100 while `outst`=1:
  - The stale response is discarded.
  - The next `id_pc` is 0x100.
  - `id_instr`=0 for the gap cycle.
- Redirect in the same cycle as `imem_rvalid` and `stall`: that word is dropped, the FIFO is empty next cycle, and `drop_cnt` is correct.
- `imem_ready` toggling randomly with 3-cycle memory: in-order PCs, no `imem_req` during `S_BOOT` or during a `redirect` cycle.
- Async reset asserted mid-stream: outputs reach reset values without a clock edge; fetch restarts at `RESET_PC`.
